// File: rtl/pkt_sram_buffer_proc_pkg.sv
// Shared types and helpers for the SRAM packet buffer with processor window.
package pkt_buf_pkg;

  typedef enum logic {
    FILL = 1'b0,
    PROC = 1'b1
  } state_t;

  localparam logic [7:0] CTRL_HDR  = 8'hFF;
  localparam logic [7:0] CTRL_DATA = 8'h00;

  // Pointers carry one extra MSB so a full ring is distinguishable from empty.
  function automatic int ptr_width(input int awidth);
    return awidth + 1;
  endfunction

endpackage

// File: rtl/pkt_sram_buffer_proc_if.sv
// Packet input, packet output and processor-window signals of the buffer.
interface pkt_sram_buffer_proc_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int AWIDTH     = 10
);
  logic [DATA_WIDTH-1:0]            in_data;
  logic [CTRL_WIDTH-1:0]            in_ctrl;
  logic                             in_wr;
  logic                             in_rdy;
  logic [DATA_WIDTH-1:0]            out_data;
  logic [CTRL_WIDTH-1:0]            out_ctrl;
  logic                             out_wr;
  logic                             out_rdy;
  logic                             pc_en;
  logic [AWIDTH-1:0]                proc_addr;
  logic [DATA_WIDTH+CTRL_WIDTH-1:0] proc_wdata;
  logic                             proc_we;
  logic [DATA_WIDTH+CTRL_WIDTH-1:0] proc_rdata;
  logic                             proc_done;
  logic [AWIDTH-1:0]                pkt_len;
  logic                             almfull;
  logic                             empty;
  logic                             stall;
  logic [15:0]                      ovf_cnt;

  modport slave (
    input  in_data, in_ctrl, in_wr, out_rdy, pc_en,
           proc_addr, proc_wdata, proc_we, proc_done,
    output in_rdy, out_data, out_ctrl, out_wr, proc_rdata,
           pkt_len, almfull, empty, stall, ovf_cnt
  );

  modport master (
    output in_data, in_ctrl, in_wr, out_rdy, pc_en,
           proc_addr, proc_wdata, proc_we, proc_done,
    input  in_rdy, out_data, out_ctrl, out_wr, proc_rdata,
           pkt_len, almfull, empty, stall, ovf_cnt
  );

endinterface

// File: rtl/pkt_sram_buffer_proc_sram.sv
// Dual-port single-clock SRAM, 1-cycle read latency; port A is write-first.
module sram_dp_1clk #(
  parameter int WIDTH  = 72,
  parameter int AWIDTH = 10
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic [AWIDTH-1:0] addr_a,
  input  logic [WIDTH-1:0]  wdata_a,
  output logic [WIDTH-1:0]  q_a,
  input  logic              we_b,
  input  logic [AWIDTH-1:0] addr_b,
  input  logic [WIDTH-1:0]  wdata_b,
  output logic [WIDTH-1:0]  q_b
);

  logic [WIDTH-1:0] mem [2**AWIDTH];

  always_ff @(posedge clk) begin
    if (we_a) begin
      mem[addr_a] <= wdata_a;
      q_a         <= wdata_a;
    end else begin
      q_a <= mem[addr_a];
    end
    if (we_b) begin
      mem[addr_b] <= wdata_b;
    end
    q_b <= mem[addr_b];
  end

endmodule

// File: rtl/pkt_sram_buffer_proc.sv
// Packet ring buffer in dual-port SRAM; optionally parks each complete packet
// in a processor window for in-place edits before it becomes readable.
//
// state | meaning
// FILL  | accepting input words; completed packets commit straight to output
// PROC  | last packet held for the processor; input stalled, drain continues
module pkt_sram_buffer_proc
  import pkt_buf_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int CTRL_WIDTH  = DATA_WIDTH / 8,
  parameter int AWIDTH      = 10,
  parameter int ALMFULL_GAP = 8,
  parameter int PROC_MODE   = 1
) (
  input logic                   clk,
  input logic                   reset_n,
  pkt_sram_buffer_proc_if.slave bus
);

  localparam int PW = ptr_width(AWIDTH);
  localparam int WW = CTRL_WIDTH + DATA_WIDTH;
  localparam logic [PW-1:0] DEPTH = PW'(1) << AWIDTH;
  localparam logic [PW-1:0] GAP   = PW'(ALMFULL_GAP);
  localparam logic [PW-1:0] ONE   = PW'(1);
  localparam logic [CTRL_WIDTH-1:0] CTRL_ZERO = CTRL_WIDTH'(CTRL_DATA);

  state_t            state;
  logic [PW-1:0]     wr_ptr, rd_ptr, commit_ptr, pkt_end, occ, free_words;
  logic [AWIDTH-1:0] pkt_base, pkt_len, addr_a;
  logic [WW-1:0]     wdata_a, q_a, q_b;
  logic              we_a, stall, almfull, in_rdy, empty, out_wr, rd_a_valid;
  logic              in_pkt, prev_data, wr_acc, is_eop, rd_en;
  logic [15:0]       ovf_cnt;

  assign occ        = wr_ptr - rd_ptr;
  assign free_words = DEPTH - occ;
  assign almfull    = free_words <= GAP;
  assign in_rdy     = ~almfull & ~stall;
  assign empty      = rd_ptr == commit_ptr;
  assign wr_acc     = bus.in_wr & in_rdy;
  // EOP: a non-zero ctrl word that follows a pure data word.
  assign is_eop     = wr_acc & prev_data & (bus.in_ctrl != CTRL_ZERO);
  assign rd_en      = bus.out_rdy & ~empty;

  always_comb begin
    addr_a  = wr_ptr[AWIDTH-1:0];
    we_a    = wr_acc;
    wdata_a = {bus.in_ctrl, bus.in_data};
    if (state == PROC) begin
      addr_a  = pkt_base + bus.proc_addr;
      we_a    = bus.proc_we & (bus.proc_addr < pkt_len);
      wdata_a = bus.proc_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pkt_base   <= '0;
      in_pkt     <= 1'b0;
      prev_data  <= 1'b0;
      ovf_cnt    <= '0;
      out_wr     <= 1'b0;
      rd_a_valid <= 1'b0;
    end else begin
      out_wr     <= rd_en;
      rd_a_valid <= (state == PROC);
      if (rd_en) begin
        rd_ptr <= rd_ptr + ONE;
      end
      if (wr_acc) begin
        wr_ptr    <= wr_ptr + ONE;
        prev_data <= (bus.in_ctrl == CTRL_ZERO);
        in_pkt    <= ~is_eop;
        if (!in_pkt) begin
          pkt_base <= wr_ptr[AWIDTH-1:0];
        end
      end
      if (bus.in_wr && !in_rdy && ovf_cnt != 16'hFFFF) begin
        ovf_cnt <= ovf_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= FILL;
      commit_ptr <= '0;
      pkt_end    <= '0;
      pkt_len    <= '0;
      stall      <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (is_eop) begin
            if (PROC_MODE != 0 && bus.pc_en) begin
              state   <= PROC;
              stall   <= 1'b1;
              pkt_len <= wr_ptr[AWIDTH-1:0] + AWIDTH'(1) - pkt_base;
              pkt_end <= wr_ptr + ONE;
            end else begin
              commit_ptr <= wr_ptr + ONE;
            end
          end
        end
        PROC: begin
          // Done and pc_en drop together still release exactly once.
          if (bus.proc_done || !bus.pc_en) begin
            state      <= FILL;
            stall      <= 1'b0;
            pkt_len    <= '0;
            commit_ptr <= pkt_end;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  sram_dp_1clk #(
    .WIDTH  (WW),
    .AWIDTH (AWIDTH)
  ) u_sram (
    .clk     (clk),
    .we_a    (we_a),
    .addr_a  (addr_a),
    .wdata_a (wdata_a),
    .q_a     (q_a),
    .we_b    (1'b0),
    .addr_b  (rd_ptr[AWIDTH-1:0]),
    .wdata_b ('0),
    .q_b     (q_b)
  );

  assign bus.in_rdy     = in_rdy;
  assign bus.almfull    = almfull;
  assign bus.empty      = empty;
  assign bus.stall      = stall;
  assign bus.pkt_len    = pkt_len;
  assign bus.ovf_cnt    = ovf_cnt;
  assign bus.out_wr     = out_wr;
  assign bus.out_data   = out_wr ? q_b[DATA_WIDTH-1:0] : '0;
  assign bus.out_ctrl   = out_wr ? q_b[WW-1:DATA_WIDTH] : '0;
  assign bus.proc_rdata = rd_a_valid ? q_a : '0;

endmodule
